sma_channel_scheduler: RTL and testbench
========================================

// Module: sma_channel_scheduler
// PURPOSE
//  Time-multiplexes a single 4-tap moving-sum datapath across CH independent sample channels.
//  Keeps per-channel tap history (3 prior samples) in local registers.
//  Arbitrates input requests round-robin and emits one result per accepted sample with channel tag.
//  Sits between the multi-channel ADC front-end and the downstream per-channel result consumer.
// PARAMETERS
//  CH     4   number of input channels (2..16)
//  W      16  sample/result width, two's-complement signed
//  CHW    2   channel-index width, must equal clog2(CH)
// PORTS
//  clk       in   1     clock, all state on rising edge
//  rst       in   1     reset, asynchronous, active-low
//  in_valid  in   CH    per-channel sample request
//  in_data   in   CH*W  per-channel samples, ch k at bits [k*W +: W]
//  in_ready  out  CH    one-hot grant; sample k consumed when in_valid[k] & in_ready[k]
//  clr       in   CH    per-channel history clear strobe
//  y_valid   out  1     result valid
//  y_ready   in   1     downstream accepts result
//  y         out  W     result, signed
//  y_ch      out  CHW   channel index of result
//  y_warm    out  1     result computed from 4 genuine samples since last clear/reset
// BEHAVIOUR
//  Reset (rst=0, async): y_valid=0, y=0, y_ch=0, y_warm=0, all history=0, warm counters=0,
//   RR pointer=CH-1 (ch0 has first priority), FSM=IDLE; in_ready=0 while rst=0.
//  Reset mid-operation: held result discarded, no handshake completes in the reset cycle.
//  FSM: IDLE (y_valid=0) / EMIT (y_valid=1). advance = (state==IDLE) | y_ready.
//   IDLE->EMIT on grant; EMIT->EMIT on y_ready & grant; EMIT->IDLE on y_ready & !grant;
//   EMIT holds y, y_ch, y_warm stable while y_ready=0.
//  Arbitration (combinational): eligible[k] = in_valid[k] & !clr[k]; if advance, grant first eligible
//   channel searching ptr+1, ptr+2, ... modulo CH; in_ready = one-hot grant, else all zero.
//   ptr <= granted channel on grant; unchanged otherwise. No channel starves: max wait CH-1 grants.
//  Datapath, on grant of ch k with sample x: sum = (x + h1[k]) + (h2[k] + h3[k]);
//   history shifts h3<=h2, h2<=h1, h1<=x; y_ch<=k; result registered -> latency 1 cycle grant->y_valid.
//  Width rule: sum computed at W+2 bits; without averaging y = sum[W-1:0] (wrap, no saturation).
//  Warm counter per channel: 2-bit saturating, increments per accepted sample, saturates at 3;
//   y_warm <= (cnt[k]==3) evaluated before the increment.
//  clr[k]=1: next edge h1..h3[k]=0, cnt[k]=0; ch k not granted that cycle (clr beats request);
//   clr of ch k does not alter an already-registered result for ch k.
//  Other channels' history/counters untouched by grants or clears of ch k.
// CONFIGURATION
//  SMA_SCHED_AVG_EN defined: y = sum >>> 2 (arithmetic shift of the W+2-bit sum, truncation toward -inf),
//   true mean, no overflow possible.
//  Undefined: y = sum[W-1:0] wrapped moving sum; identical timing and handshake in both builds.
// STRUCTURE
//  Shared defs include sma_sched_defs.v: FSM state encodings (IDLE=1'b0, EMIT=1'b1),
//   default W/CH/CHW, warm-counter saturation value 2'd3.
//  One sub-module: sma_rr_arbiter (CH-wide round-robin, inputs req/advance/ptr, outputs one-hot grant+index).
//  History array, warm counters, sum/shift logic and FSM stay in this module.
// TESTING
//  Single ch0 stream 1,2,3,4,5 (y_ready=1) -> y=1,3,6,10,14 each 1 cycle after grant; y_warm 0,0,0,1,1.
//  All 4 ch valid every cycle, y_ready=1 -> grants 0,1,2,3,0,... one per cycle, y_ch matches, no gaps.
//  ch2 feeds 0x7FFF x4 -> y=0xFFFC (wrap); with SMA_SCHED_AVG_EN -> y=0x7FFF.
//  y_ready=0 for 5 cycles with y_valid=1 -> y/y_ch stable, in_ready all 0; release -> next grant same cycle.
//  ch1 history 10,20,30 then clr[1] with in_valid[1]=1 -> no grant to ch1 that cycle; next sample 7 -> y=7, y_warm=0.
//  Assert rst=0 while EMIT with ch3 pending -> y_valid=0 immediately; after release ch0 granted first, history=0.

Source files
------------

// File: rtl/sma_channel_scheduler_pkg.sv
// Shared definitions for the SMA channel scheduler: FSM states, default sizes and warm-counter helpers.
package sma_channel_scheduler_pkg;

  localparam int DEF_CH  = 4;
  localparam int DEF_W   = 16;
  localparam int DEF_CHW = 2;

  localparam logic [1:0] WARM_SAT = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [1:0] warm_inc(input logic [1:0] cnt);
    return (cnt == WARM_SAT) ? cnt : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/sma_channel_scheduler_if.sv
// Sample-request and result handshake bundle for the SMA channel scheduler.
interface sma_channel_scheduler_if
  import sma_channel_scheduler_pkg::*;
#(
  parameter int CH  = DEF_CH,
  parameter int W   = DEF_W,
  parameter int CHW = DEF_CHW
);
  logic [CH-1:0]   in_valid;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_ready;
  logic [CH-1:0]   clr;
  logic            y_valid;
  logic            y_ready;
  logic [W-1:0]    y;
  logic [CHW-1:0]  y_ch;
  logic            y_warm;

  modport master (
    output in_valid, in_data, clr, y_ready,
    input  in_ready, y_valid, y, y_ch, y_warm
  );

  modport slave (
    input  in_valid, in_data, clr, y_ready,
    output in_ready, y_valid, y, y_ch, y_warm
  );
endinterface

// File: rtl/sma_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr (wrapping modulo CH) when advance is high.
module sma_rr_arbiter #(
  parameter int CH  = 4,
  parameter int CHW = 2
) (
  input  logic [CH-1:0]  req,
  input  logic           advance,
  input  logic [CHW-1:0] ptr,
  output logic [CH-1:0]  grant,
  output logic [CHW-1:0] grant_idx,
  output logic           grant_any
);

  int             c;
  logic [CHW-1:0] cidx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    c         = 0;
    cidx      = '0;
    if (advance) begin
      // Offsets 1..CH put the last-granted channel at the lowest priority.
      for (int i = 1; i <= CH; i++) begin
        c    = (int'(ptr) + i) % CH;
        cidx = CHW'(c);
        if (!grant_any && req[cidx]) begin
          grant_any   = 1'b1;
          grant[cidx] = 1'b1;
          grant_idx   = cidx;
        end
      end
    end
  end

endmodule

// File: rtl/sma_channel_scheduler.sv
// Shares one 4-tap moving-sum datapath across CH channels with round-robin input arbitration.
// Define SMA_SCHED_AVG_EN to output the arithmetic mean (sum >>> 2) instead of the wrapped sum.
module sma_channel_scheduler
  import sma_channel_scheduler_pkg::*;
#(
  parameter int CH  = DEF_CH,
  parameter int W   = DEF_W,
  parameter int CHW = DEF_CHW
) (
  input logic                    clk,
  input logic                    rst,
  sma_channel_scheduler_if.slave bus
);

`ifdef SMA_SCHED_AVG_EN
  localparam int SUM_W = W + 2;
`else
  // Wrapped output only needs the low W bits, which match those of the W+2-bit sum.
  localparam int SUM_W = W;
`endif

  state_t          state_reg, state_next;
  logic [CHW-1:0]  ptr_reg;
  logic [W-1:0]    y_reg;
  logic [CHW-1:0]  y_ch_reg;
  logic            y_warm_reg;
  logic            emit;

  logic            advance;
  logic [CH-1:0]   eligible;
  logic [CH-1:0]   grant;
  logic [CHW-1:0]  grant_idx;
  logic            grant_any;

  logic [CH*W-1:0] h1_flat, h2_flat, h3_flat;
  logic [CH*2-1:0] cnt_flat;

  logic [W-1:0]     x_sel, h1_sel, h2_sel, h3_sel;
  logic [1:0]       cnt_sel;
  logic signed [SUM_W-1:0] sum;
  logic [W-1:0]     result;

  function automatic logic signed [SUM_W-1:0] ext(input logic [W-1:0] v);
    return SUM_W'($signed(v));
  endfunction

  // No handshake may complete while reset is asserted.
  assign advance  = rst & ((state_reg == IDLE) | bus.y_ready);
  assign eligible = bus.in_valid & ~bus.clr;

  sma_rr_arbiter #(
    .CH  (CH),
    .CHW (CHW)
  ) u_arb (
    .req       (eligible),
    .advance   (advance),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.in_ready = grant;

  always_comb begin
    x_sel   = bus.in_data[grant_idx*W +: W];
    h1_sel  = h1_flat[grant_idx*W +: W];
    h2_sel  = h2_flat[grant_idx*W +: W];
    h3_sel  = h3_flat[grant_idx*W +: W];
    cnt_sel = cnt_flat[grant_idx*2 +: 2];
    sum     = (ext(x_sel) + ext(h1_sel)) + (ext(h2_sel) + ext(h3_sel));
  end

`ifdef SMA_SCHED_AVG_EN
  assign result = W'(sum >>> 2);
`else
  assign result = sum;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] h1_reg, h2_reg, h3_reg;
      logic [1:0]   cnt_reg;

      // Clear wins over a grant; the arbiter never grants a clearing channel anyway.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          h1_reg  <= '0;
          h2_reg  <= '0;
          h3_reg  <= '0;
          cnt_reg <= '0;
        end else if (bus.clr[gi]) begin
          h1_reg  <= '0;
          h2_reg  <= '0;
          h3_reg  <= '0;
          cnt_reg <= '0;
        end else if (grant[gi]) begin
          h3_reg  <= h2_reg;
          h2_reg  <= h1_reg;
          h1_reg  <= x_sel;
          cnt_reg <= warm_inc(cnt_reg);
        end
      end

      assign h1_flat[gi*W +: W]  = h1_reg;
      assign h2_flat[gi*W +: W]  = h2_reg;
      assign h3_flat[gi*W +: W]  = h3_reg;
      assign cnt_flat[gi*2 +: 2] = cnt_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) state_next = EMIT;
      end
      EMIT: begin
        emit = 1'b1;
        if (bus.y_ready && !grant_any) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= CHW'(CH - 1);
      y_reg      <= '0;
      y_ch_reg   <= '0;
      y_warm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // A grant only occurs when the held result is free to be replaced.
      if (grant_any) begin
        ptr_reg    <= grant_idx;
        y_reg      <= result;
        y_ch_reg   <= grant_idx;
        y_warm_reg <= (cnt_sel == WARM_SAT);
      end
    end
  end

  assign bus.y_valid = emit;
  assign bus.y       = y_reg;
  assign bus.y_ch    = y_ch_reg;
  assign bus.y_warm  = y_warm_reg;

endmodule

// File: tb/tb_sma_channel_scheduler.sv
// Self-checking bench for sma_channel_scheduler: reference-model scoreboard plus vector table and corner sequences.
module tb_sma_channel_scheduler;

  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int CHW = 2;

  logic clk;
  logic rst;

  sma_channel_scheduler_if #(.CH(CH), .W(W), .CHW(CHW)) bus ();

  sma_channel_scheduler #(.CH(CH), .W(W), .CHW(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0]   y;
    logic [CHW-1:0] ch;
    logic           warm;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mh1[CH];
  logic [W-1:0] mh2[CH];
  logic [W-1:0] mh3[CH];
  int           mcnt[CH];
  int           mptr;

  typedef struct {
    logic [CH-1:0]   valid;
    logic [CH*W-1:0] data;
    logic [CH-1:0]   clr;
    logic            yr;
    logic [CH-1:0]   exp_rdy;
    logic            exp_yv;
    logic            chk_y;
    logic [W-1:0]    exp_y;
    logic            exp_warm;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mptr = CH - 1;
    for (int k = 0; k < CH; k++) begin
      mh1[k] = '0; mh2[k] = '0; mh3[k] = '0; mcnt[k] = 0;
    end
  endtask

  // Reference model, evaluated once per cycle on the falling edge.
  task automatic monitor();
    logic [CH-1:0] elig;
    logic [CH-1:0] exp_rdy;
    logic [W-1:0]  x;
    bit            adv;
    int            g;
    int            c;
    int            s;
    exp_t          e;
    if (!rst) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
      chk("rst_y", 32'(bus.y), 32'd0);
      chk("rst_y_ch", 32'(bus.y_ch), 32'd0);
      chk("rst_y_warm", 32'(bus.y_warm), 32'd0);
      model_reset();
      return;
    end
    chk("y_valid", 32'(bus.y_valid), 32'(q.size() != 0));
    adv = (q.size() == 0) || bus.y_ready;
    if (q.size() != 0) begin
      if (bus.y_valid) begin
        chk("sb_y", 32'(bus.y), 32'(q[0].y));
        chk("sb_y_ch", 32'(bus.y_ch), 32'(q[0].ch));
        chk("sb_y_warm", 32'(bus.y_warm), 32'(q[0].warm));
      end
      if (bus.y_ready) void'(q.pop_front());
    end
    elig = bus.in_valid & ~bus.clr;
    g = -1;
    if (adv) begin
      for (int i = 1; i <= CH; i++) begin
        c = (mptr + i) % CH;
        if (g < 0 && elig[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? CH'(1 << g) : '0;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (g >= 0) begin
      x = bus.in_data[g*W +: W];
      s = int'($signed(x)) + int'($signed(mh1[g])) + int'($signed(mh2[g])) + int'($signed(mh3[g]));
`ifdef SMA_SCHED_AVG_EN
      e.y = W'(s >>> 2);
`else
      e.y = W'(s);
`endif
      e.ch   = CHW'(g);
      e.warm = (mcnt[g] == 3);
      q.push_back(e);
      mh3[g] = mh2[g]; mh2[g] = mh1[g]; mh1[g] = x;
      if (mcnt[g] < 3) mcnt[g]++;
      mptr = g;
    end
    for (int k = 0; k < CH; k++) begin
      if (bus.clr[k]) begin
        mh1[k] = '0; mh2[k] = '0; mh3[k] = '0; mcnt[k] = 0;
      end
    end
  endtask

  task automatic drive(input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                       input logic [CH-1:0] c, input logic yr);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clr      = c;
    bus.y_ready  = yr;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                         input logic [CH-1:0] rdy, input logic yv, input logic cy,
                         input logic [W-1:0] y, input logic wm);
    vecs[i] = '{valid: v, data: d, clr: '0, yr: 1'b1, exp_rdy: rdy, exp_yv: yv,
                chk_y: cy, exp_y: y, exp_warm: wm};
  endtask

  logic [W-1:0] held_y;
  logic [CHW-1:0] held_ch;
  logic [W-1:0] wrap_exp;

  initial begin
    // ch0 stream 1..5, then round-robin with all channels requesting.
    set_vec(0,  4'b0001, {16'd0, 16'd0, 16'd0, 16'd1}, 4'b0001, 1'b0, 1'b0, 16'd0,  1'b0);
    set_vec(1,  4'b0001, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001, 1'b1, 1'b1, 16'd1,  1'b0);
    set_vec(2,  4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0001, 1'b1, 1'b1, 16'd3,  1'b0);
    set_vec(3,  4'b0001, {16'd0, 16'd0, 16'd0, 16'd4}, 4'b0001, 1'b1, 1'b1, 16'd6,  1'b0);
    set_vec(4,  4'b0001, {16'd0, 16'd0, 16'd0, 16'd5}, 4'b0001, 1'b1, 1'b1, 16'd10, 1'b1);
    set_vec(5,  4'b0000, '0,                            4'b0000, 1'b1, 1'b1, 16'd14, 1'b1);
    set_vec(6,  4'b0000, '0,                            4'b0000, 1'b0, 1'b0, 16'd0,  1'b0);
    set_vec(7,  4'b1111, {16'd40, 16'd30, 16'd20, 16'd10}, 4'b0010, 1'b0, 1'b0, 16'd0, 1'b0);
    set_vec(8,  4'b1111, {16'd41, 16'd31, 16'd21, 16'd11}, 4'b0100, 1'b1, 1'b0, 16'd0, 1'b0);
    set_vec(9,  4'b1111, {16'd42, 16'd32, 16'd22, 16'd12}, 4'b1000, 1'b1, 1'b0, 16'd0, 1'b0);
    set_vec(10, 4'b1111, {16'hFFF0, 16'd33, 16'd23, 16'd13}, 4'b0001, 1'b1, 1'b0, 16'd0, 1'b0);
    set_vec(11, 4'b1111, {16'd44, 16'd34, 16'hFFFF, 16'd14}, 4'b0010, 1'b1, 1'b0, 16'd0, 1'b0);
    set_vec(12, 4'b0000, '0,                               4'b0000, 1'b1, 1'b0, 16'd0, 1'b0);

    model_reset();
    rst = 1'b0;
    drive('0, '0, '0, 1'b1);
    repeat (2) begin
      sample();
      next_cycle();
    end
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].clr, vecs[i].yr);
      sample();
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_y_valid", i), 32'(bus.y_valid), 32'(vecs[i].exp_yv));
      if (vecs[i].chk_y) begin
        chk($sformatf("vec%0d_y", i), 32'(bus.y), 32'(vecs[i].exp_y));
        chk($sformatf("vec%0d_y_ch", i), 32'(bus.y_ch), 32'd0);
        chk($sformatf("vec%0d_y_warm", i), 32'(bus.y_warm), 32'(vecs[i].exp_warm));
      end
      next_cycle();
    end

    // ch2 saturating-magnitude input: wrap in the sum build, exact mean in the averaging build.
`ifdef SMA_SCHED_AVG_EN
    wrap_exp = 16'h7FFF;
`else
    wrap_exp = 16'hFFFC;
`endif
    drive('0, '0, 4'b0100, 1'b1);
    sample();
    next_cycle();
    repeat (4) begin
      drive(4'b0100, {16'd0, 16'h7FFF, 16'd0, 16'd0}, '0, 1'b1);
      sample();
      next_cycle();
    end
    drive('0, '0, '0, 1'b1);
    sample();
    chk("ch2_wrap_y", 32'(bus.y), 32'(wrap_exp));
    chk("ch2_wrap_y_ch", 32'(bus.y_ch), 32'd2);
    chk("ch2_wrap_warm", 32'(bus.y_warm), 32'd1);
    next_cycle();

    // Backpressure: result held for 5 cycles, no grants, then release grants immediately.
    drive(4'b0011, {16'd0, 16'd0, 16'd2, 16'd1}, '0, 1'b0);
    sample();
    next_cycle();
    sample();
    held_y  = bus.y;
    held_ch = bus.y_ch;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_y_valid", 32'(bus.y_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_y_stable", 32'(bus.y), 32'(held_y));
      chk("bp_y_ch_stable", 32'(bus.y_ch), 32'(held_ch));
      next_cycle();
    end
    bus.y_ready = 1'b1;
    sample();
    chk("bp_release_grant", 32'(bus.in_ready), 32'b0010);
    next_cycle();
    drive('0, '0, '0, 1'b1);
    repeat (2) begin
      sample();
      next_cycle();
    end

    // ch1: build history, clear while requesting, then a fresh sample.
    drive('0, '0, 4'b0010, 1'b1);
    sample();
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      drive(4'b0010, {16'd0, 16'd0, 16'(10 * i), 16'd0}, '0, 1'b1);
      sample();
      next_cycle();
    end
    drive(4'b0010, {16'd0, 16'd0, 16'd99, 16'd0}, 4'b0010, 1'b1);
    sample();
    chk("clr_blocks_grant", 32'(bus.in_ready), 32'd0);
    next_cycle();
    drive(4'b0010, {16'd0, 16'd0, 16'd7, 16'd0}, '0, 1'b1);
    sample();
    next_cycle();
    drive('0, '0, '0, 1'b1);
    sample();
    chk("clr_y", 32'(bus.y), 32'd7);
    chk("clr_y_ch", 32'(bus.y_ch), 32'd1);
    chk("clr_y_warm", 32'(bus.y_warm), 32'd0);
    next_cycle();

    // Reset while a result is held and ch3 waits.
    drive(4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, '0, 1'b0);
    sample();
    next_cycle();
    drive(4'b1001, {16'd9, 16'd0, 16'd0, 16'd3}, '0, 1'b0);
    sample();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("midrst_y_valid", 32'(bus.y_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    sample();
    next_cycle();
    rst = 1'b1;
    drive(4'b1001, {16'd9, 16'd0, 16'd0, 16'd5}, '0, 1'b1);
    sample();
    chk("postrst_grant_ch0", 32'(bus.in_ready), 32'b0001);
    next_cycle();
    drive('0, '0, '0, 1'b1);
    sample();
    chk("postrst_y", 32'(bus.y), 32'd5);
    chk("postrst_y_ch", 32'(bus.y_ch), 32'd0);
    chk("postrst_y_warm", 32'(bus.y_warm), 32'd0);
    next_cycle();
    sample();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
